// File: rtl/pl_branch_pkg.sv
// Shared opcode/funct3 constants and the PC-source select encoding for the
// execute-stage branch resolution unit.
package pl_branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    PCSRC_SEQ   = 2'b00,
    PCSRC_BR    = 2'b01,
    PCSRC_RECOV = 2'b10,
    PCSRC_JUMP  = 2'b11
  } pcsrc_t;

endpackage

// File: rtl/pl_branch_cond.sv
// Combinational branch condition evaluator: maps funct3 and ALU flags to the
// actual outcome; funct3 010/011 are not branches.
module pl_branch_cond
  import pl_branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       ult_i,
  output logic       taken_o,
  output logic       is_valid_branch_o
);

  always_comb begin
    taken_o           = 1'b0;
    is_valid_branch_o = 1'b1;
    case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = ~zero_i;
      F3_BLT:  taken_o = neg_i;
      F3_BGE:  taken_o = ~neg_i;
      F3_BLTU: taken_o = ult_i;
      F3_BGEU: taken_o = ~ult_i;
      default: is_valid_branch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pl_branch_resolve_bht.sv
// Execute-stage branch/jump resolution with a BHT of saturating counters:
// fetch-side lookup, redirect select, mispredict flag, training and stats.
module pl_branch_resolve_bht
  import pl_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int PRED_ENABLE = 1,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pcF,
  output logic              predict_takenF,
  input  logic              validE,
  input  logic              stallE,
  input  logic [6:0]        opcodeE,
  input  logic [2:0]        funct3E,
  input  logic [XLEN-1:0]   pcE,
  input  logic              predictedE,
  input  logic              ZeroFlag,
  input  logic              NegativeFlag,
  input  logic              UnsignedLess,
  output logic [1:0]        PCSrcE,
  output logic              mispredictE,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic PRED_EN = (PRED_ENABLE != 0);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  logic [CNT_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [STAT_W-1:0]   branch_cnt_q, mispred_cnt_q;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic             taken, valid_f3, is_br, is_jump, pred_eff, upd;
  logic             mispred;
  pcsrc_t           pcsrc;

  assign idx_f = pcF[IDX_W+1:2];
  assign idx_e = pcE[IDX_W+1:2];

  // Bits outside the index field never affect the result.
  logic unused_pc;
  assign unused_pc = ^{pcF[XLEN-1:IDX_W+2], pcF[1:0], pcE[XLEN-1:IDX_W+2], pcE[1:0]};

  pl_branch_cond u_cond (
    .funct3_i          (funct3E),
    .zero_i            (ZeroFlag),
    .neg_i             (NegativeFlag),
    .ult_i             (UnsignedLess),
    .taken_o           (taken),
    .is_valid_branch_o (valid_f3)
  );

  assign predict_takenF = bht_q[idx_f][CNT_BITS-1] & PRED_EN;
  assign pred_eff       = predictedE & PRED_EN;
  assign is_br          = (opcodeE == OP_BRANCH) && valid_f3;
  assign is_jump        = (opcodeE == OP_JAL) || (opcodeE == OP_JALR);
  assign upd            = validE & ~stallE & is_br;

  always_comb begin
    pcsrc   = PCSRC_SEQ;
    mispred = 1'b0;
    if (validE) begin
      if (is_jump) begin
        pcsrc   = PCSRC_JUMP;
        mispred = 1'b1;
      end else if (is_br) begin
        if (taken && !pred_eff) begin
          pcsrc   = PCSRC_BR;
          mispred = 1'b1;
        end else if (!taken && pred_eff) begin
          pcsrc   = PCSRC_RECOV;
          mispred = 1'b1;
        end
      end
    end
  end

  assign PCSrcE      = pcsrc;
  assign mispredictE = mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_WNT;
    end else if (upd && PRED_EN) begin
      if (taken && bht_q[idx_e] != CNT_MAX)
        bht_q[idx_e] <= bht_q[idx_e] + CNT_BITS'(1);
      else if (!taken && bht_q[idx_e] != '0)
        bht_q[idx_e] <= bht_q[idx_e] - CNT_BITS'(1);
    end
  end

  // Stat counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (upd) begin
      if (~&branch_cnt_q) branch_cnt_q <= branch_cnt_q + STAT_W'(1);
      if (mispred && ~&mispred_cnt_q) mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_pl_branch_resolve_bht.sv
module tb_pl_branch_resolve_bht;
  import pl_branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcF, pcE;
  logic        validE, stallE, predictedE, ZeroFlag, NegativeFlag, UnsignedLess;
  logic [6:0]  opcodeE;
  logic [2:0]  funct3E;

  logic        predF1, mispr1, predF2, mispr2;
  logic [1:0]  pcsrc1, pcsrc2;
  logic [31:0] bcnt1, mcnt1, bcnt2, mcnt2;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  pl_branch_resolve_bht #(.PRED_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predict_takenF(predF1),
    .validE(validE), .stallE(stallE), .opcodeE(opcodeE), .funct3E(funct3E),
    .pcE(pcE), .predictedE(predictedE), .ZeroFlag(ZeroFlag),
    .NegativeFlag(NegativeFlag), .UnsignedLess(UnsignedLess),
    .PCSrcE(pcsrc1), .mispredictE(mispr1), .branch_cnt(bcnt1), .mispred_cnt(mcnt1)
  );

  pl_branch_resolve_bht #(.PRED_ENABLE(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predict_takenF(predF2),
    .validE(validE), .stallE(stallE), .opcodeE(opcodeE), .funct3E(funct3E),
    .pcE(pcE), .predictedE(predictedE), .ZeroFlag(ZeroFlag),
    .NegativeFlag(NegativeFlag), .UnsignedLess(UnsignedLess),
    .PCSrcE(pcsrc2), .mispredictE(mispr2), .branch_cnt(bcnt2), .mispred_cnt(mcnt2)
  );

  typedef enum int {S_PRED, S_PCSRC, S_MISP, S_BCNT, S_MCNT, S_PRED2, S_PCSRC2, S_BCNT2} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_v(input string name, input sel_t sel, input logic [31:0] v);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = v;
    q.push_back(c);
  endtask

  task automatic step(input logic v, input logic st, input logic [6:0] op,
                      input logic [2:0] f3, input logic [31:0] pe, input logic pr,
                      input logic z, input logic n, input logic u, input logic [31:0] pf);
    @(posedge clk); #1;
    validE = v; stallE = st; opcodeE = op; funct3E = f3; pcE = pe;
    predictedE = pr; ZeroFlag = z; NegativeFlag = n; UnsignedLess = u; pcF = pf;
  endtask

  task automatic idle(input logic [31:0] pf);
    step(1'b0, 1'b0, 7'h00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, pf);
  endtask

  task automatic exp_res(input string name, input logic [1:0] ps, input logic m);
    expect_v({name, ".pcsrc"}, S_PCSRC, 32'(ps));
    expect_v({name, ".mispred"}, S_MISP, 32'(m));
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.sel)
        S_PRED:   act = 32'(predF1);
        S_PCSRC:  act = 32'(pcsrc1);
        S_MISP:   act = 32'(mispr1);
        S_BCNT:   act = bcnt1;
        S_MCNT:   act = mcnt1;
        S_PRED2:  act = 32'(predF2);
        S_PCSRC2: act = 32'(pcsrc2);
        default:  act = bcnt2;
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: sequence did not complete");
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    validE = 0; stallE = 0; opcodeE = 0; funct3E = 0; pcE = 0; pcF = 0;
    predictedE = 0; ZeroFlag = 0; NegativeFlag = 0; UnsignedLess = 0;
    repeat (2) @(posedge clk);

    idle(32'h100); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (predF1 !== 1'b0 || bcnt1 !== 32'h0 || mcnt1 !== 32'h0 ||
        predF2 !== 1'b0 || bcnt2 !== 32'h0 || mcnt2 !== 32'h0) begin
      n_bad++;
      $display("FAIL rst.direct: pred=%0b bcnt=%0h mcnt=%0h", predF1, bcnt1, mcnt1);
    end
    expect_v("rst.pred100", S_PRED, 0);
    expect_v("rst.bcnt", S_BCNT, 0);
    expect_v("rst.mcnt", S_MCNT, 0);
    exp_res("rst", 2'b00, 1'b0);
    idle(32'h104); expect_v("rst.pred104", S_PRED, 0);
    idle(32'h1FC); expect_v("rst.pred1fc", S_PRED, 0);

    step(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 0, 1, 0, 0, 32'h100);
    exp_res("beq1", 2'b01, 1'b1);
    expect_v("beq1.pre_update_pred", S_PRED, 0);
    expect_v("beq1.np_pcsrc", S_PCSRC2, 1);
    idle(32'h100);
    expect_v("beq1.pred", S_PRED, 1);
    expect_v("beq1.bcnt", S_BCNT, 1);
    expect_v("beq1.mcnt", S_MCNT, 1);
    expect_v("beq1.np_pred", S_PRED2, 0);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 1, 1, 0, 0, 32'h100);
      exp_res("beq_sat", 2'b00, 1'b0);
      expect_v("beq_sat.np_pcsrc", S_PCSRC2, 1);
    end
    step(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 1, 0, 0, 0, 32'h100);
    exp_res("beq_nt", 2'b10, 1'b1);
    expect_v("beq_nt.np_pcsrc", S_PCSRC2, 0);
    idle(32'h100);
    expect_v("beq_nt.pred", S_PRED, 1);
    expect_v("beq_nt.bcnt", S_BCNT, 5);
    expect_v("beq_nt.mcnt", S_MCNT, 2);
    step(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 1, 0, 0, 0, 32'h100);
    exp_res("beq_nt2", 2'b10, 1'b1);
    idle(32'h100);
    expect_v("beq_nt2.pred", S_PRED, 0);

    step(1, 0, OP_JAL, 3'b000, 32'h100, 0, 1, 0, 0, 32'h100);
    exp_res("jal", 2'b11, 1'b1);
    step(1, 0, OP_JALR, 3'b000, 32'h100, 0, 1, 0, 0, 32'h100);
    exp_res("jalr", 2'b11, 1'b1);
    step(0, 0, OP_JAL, 3'b000, 32'h100, 0, 1, 0, 0, 32'h100);
    exp_res("jal_bubble", 2'b00, 1'b0);
    idle(32'h100);
    expect_v("jump.bcnt", S_BCNT, 6);
    expect_v("jump.mcnt", S_MCNT, 3);
    expect_v("jump.pred", S_PRED, 0);

    for (int i = 0; i < 3; i++) begin
      step(1, 1, OP_BRANCH, F3_BLTU, 32'h104, 0, 0, 0, 1, 32'h104);
      exp_res("bltu_stall", 2'b01, 1'b1);
    end
    step(1, 0, OP_BRANCH, F3_BLTU, 32'h104, 0, 0, 0, 1, 32'h104);
    exp_res("bltu_go", 2'b01, 1'b1);
    idle(32'h104);
    expect_v("bltu.bcnt", S_BCNT, 7);
    expect_v("bltu.mcnt", S_MCNT, 4);
    expect_v("bltu.pred", S_PRED, 1);

    step(1, 0, OP_BRANCH, 3'b010, 32'h104, 0, 1, 1, 1, 32'h104);
    exp_res("f3_010", 2'b00, 1'b0);
    idle(32'h104);
    expect_v("f3_010.bcnt", S_BCNT, 7);

    step(1, 0, OP_BRANCH, F3_BLT, 32'h108, 1, 0, 1, 0, 32'h108);
    exp_res("blt", 2'b00, 1'b0);
    expect_v("blt.np_pcsrc", S_PCSRC2, 1);
    step(1, 0, OP_BRANCH, F3_BGE, 32'h108, 1, 0, 1, 0, 32'h108);
    exp_res("bge", 2'b10, 1'b1);
    step(1, 0, OP_BRANCH, F3_BGEU, 32'h108, 0, 0, 0, 1, 32'h108);
    exp_res("bgeu", 2'b00, 1'b0);
    idle(32'h108);
    expect_v("mix.bcnt", S_BCNT, 10);
    expect_v("mix.mcnt", S_MCNT, 5);
    expect_v("mix.pred", S_PRED, 0);
    step(1, 0, OP_BRANCH, F3_BNE, 32'h108, 0, 0, 0, 0, 32'h108);
    exp_res("bne_a", 2'b01, 1'b1);
    idle(32'h108);
    expect_v("bne_a.pred", S_PRED, 0);

    idle(32'h104);
    expect_v("pre_rst.pred104", S_PRED, 1);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    n_cmp++;
    if (predF1 !== 1'b0 || bcnt1 !== 32'h0 || mcnt1 !== 32'h0 || bcnt2 !== 32'h0) begin
      n_bad++;
      $display("FAIL arst.direct: pred=%0b bcnt=%0h mcnt=%0h", predF1, bcnt1, mcnt1);
    end
    expect_v("arst.pred104", S_PRED, 0);
    expect_v("arst.bcnt", S_BCNT, 0);
    expect_v("arst.mcnt", S_MCNT, 0);
    expect_v("arst.np_bcnt", S_BCNT2, 0);
    idle(32'h104); rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(1, 0, OP_BRANCH, F3_BNE, 32'h100, 1, 0, 0, 0, 32'h100);
      expect_v("np_bne.pcsrc", S_PCSRC2, 1);
      expect_v("np_bne.pred", S_PRED2, 0);
      exp_res("bne_on", 2'b00, 1'b0);
    end
    idle(32'h100);
    expect_v("np_bne.pred_after", S_PRED2, 0);
    expect_v("np_bne.bcnt", S_BCNT2, 3);
    expect_v("bne_on.pred", S_PRED, 1);
    expect_v("bne_on.bcnt", S_BCNT, 3);

    @(posedge clk);
    @(negedge clk); #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) $display("FAIL: %0d mismatches", n_bad);
    else            $display("PASS");
    $finish;
  end

endmodule
